display_scheduler: RTL and testbench

DISPLAY_SCHEDULER -- requirements
Module: display_scheduler

---
 rtl/display_pkg.sv | 22 ++
 rtl/scan_timer.sv | 37 +++
 rtl/display_scheduler.sv | 131 +++++++++++++
 tb/tb_display_scheduler.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// rtl/display_pkg.sv - shared types and constants for the display scheduler
//
// Contents:
//   state_t    scheduler FSM states (IDLE, GRANT, CAPTURE)
//   SEG_BLANK  all segments off (active-low)
//   SEG_ZERO   pattern for digit 0, also the reset pattern
//   AN_TENS    anode code selecting the tens digit
//   AN_UNITS   anode code selecting the units digit
package display_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT   = 2'd1,
    ST_CAPTURE = 2'd2
  } state_t;

  localparam logic [0:6] SEG_BLANK = 7'b1111111;
  localparam logic [0:6] SEG_ZERO  = 7'b0000001;
  localparam logic [1:0] AN_TENS   = 2'b10;
  localparam logic [1:0] AN_UNITS  = 2'b01;

endpackage

// File: rtl/scan_timer.sv
// rtl/scan_timer.sv - digit scan divider and tens/units select toggle
//
// Ports:
//   clk        clock, rising edge
//   rst_n      synchronous active-low reset
//   wrap       high in the last cycle of a scan slot (counter at SCAN_DIV-1)
//   sel_units  current digit select: 0 = tens, 1 = units
module scan_timer #(
  parameter int SCAN_DIV = 50000
) (
  input  logic clk,
  input  logic rst_n,
  output logic wrap,
  output logic sel_units
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [CW-1:0] cnt;

  // wrap is combinational so the top can see the upcoming select toggle
  // and update its segment/anode registers on the same edge.
  assign wrap = (cnt == CW'(SCAN_DIV - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt       <= '0;
      sel_units <= 1'b0;
    end else if (wrap) begin
      cnt       <= '0;
      sel_units <= ~sel_units;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/display_scheduler.sv
// rtl/display_scheduler.sv - round-robin sharing of one BCD/7-seg converter with 2-digit scan
//
// Build option: LEADING_ZERO_BLANK_EN blanks the tens digit when the captured tens value is 0.
//
// Ports:
//   clk, rst_n             clock and synchronous active-low reset
//   req_a/req_b            conversion requests
//   val_a/val_b            4-bit values to convert
//   gnt_a/gnt_b            one-cycle grant pulses
//   conv_in                registered operand to the external converter
//   conv_decs/conv_unis    converter BCD result
//   conv_dis1/conv_dis2    converter tens/units segment patterns (active-low)
//   decs_q/unis_q          captured BCD of the last conversion
//   seg, an                multiplexed segment bus and active-low anodes
//   busy                   high whenever the FSM is not idle
module display_scheduler
  import display_pkg::*;
#(
  parameter int SCAN_DIV = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_a,
  input  logic       req_b,
  input  logic [3:0] val_a,
  input  logic [3:0] val_b,
  output logic       gnt_a,
  output logic       gnt_b,
  output logic [3:0] conv_in,
  input  logic [3:0] conv_decs,
  input  logic [3:0] conv_unis,
  input  logic [0:6] conv_dis1,
  input  logic [0:6] conv_dis2,
  output logic [3:0] decs_q,
  output logic [3:0] unis_q,
  output logic [0:6] seg,
  output logic [1:0] an,
  output logic       busy
);

  state_t     state, state_nx;
  logic       last_b;     // most recent grant went to B
  logic       win_b;      // winner of the operation in flight
  logic       pick_b;
  logic       capture;
  logic [0:6] dis1_q, dis2_q;
  logic [0:6] dis1_nx, dis2_nx, tens_pat;
  logic       wrap, sel_units, sel_nx;

  // Both requesting: the side not granted last wins.
  assign pick_b  = req_b && (!req_a || !last_b);
  assign capture = (state == ST_CAPTURE);

  always_comb begin
    state_nx = state;
    gnt_a    = 1'b0;
    gnt_b    = 1'b0;
    busy     = (state != ST_IDLE);
    case (state)
      ST_IDLE:    if (req_a || req_b) state_nx = ST_GRANT;
      ST_GRANT: begin
        gnt_a    = !win_b;
        gnt_b    = win_b;
        state_nx = ST_CAPTURE;
      end
      ST_CAPTURE: state_nx = ST_IDLE;
      default:    state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      last_b  <= 1'b1;
      win_b   <= 1'b0;
      conv_in <= 4'd0;
    end else begin
      state <= state_nx;
      if (state == ST_IDLE && (req_a || req_b)) begin
        win_b   <= pick_b;
        last_b  <= pick_b;
        conv_in <= pick_b ? val_b : val_a;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      decs_q <= 4'd0;
      unis_q <= 4'd0;
      dis1_q <= SEG_ZERO;
      dis2_q <= SEG_ZERO;
    end else if (capture) begin
      decs_q <= conv_decs;
      unis_q <= conv_unis;
      dis1_q <= conv_dis1;
      dis2_q <= conv_dis2;
    end
  end

  scan_timer #(.SCAN_DIV(SCAN_DIV)) u_scan (
    .clk       (clk),
    .rst_n     (rst_n),
    .wrap      (wrap),
    .sel_units (sel_units)
  );

  // seg/an are computed from the post-edge select and patterns so they move
  // on exactly the edge where the select toggles or a capture lands.
  always_comb begin
    sel_nx  = sel_units ^ wrap;
    dis1_nx = capture ? conv_dis1 : dis1_q;
    dis2_nx = capture ? conv_dis2 : dis2_q;
`ifdef LEADING_ZERO_BLANK_EN
    tens_pat = ((capture ? conv_decs : decs_q) == 4'd0) ? SEG_BLANK : dis1_nx;
`else
    tens_pat = dis1_nx;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      an  <= AN_TENS;
      seg <= SEG_ZERO;
    end else if (wrap || capture) begin
      an  <= sel_nx ? AN_UNITS : AN_TENS;
      seg <= sel_nx ? dis2_nx : tens_pat;
    end
  end

endmodule

// File: tb/tb_display_scheduler.sv
// tb/tb_display_scheduler.sv - scoreboard bench for display_scheduler
module tb_display_scheduler;

  localparam int SCAN_DIV = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_a, req_b;
  logic [3:0] val_a, val_b;
  logic       gnt_a, gnt_b;
  logic [3:0] conv_in, conv_decs, conv_unis;
  logic [0:6] conv_dis1, conv_dis2;
  logic [3:0] decs_q, unis_q;
  logic [0:6] seg;
  logic [1:0] an;
  logic       busy;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed {
    logic       is_b;
    logic [3:0] val;
  } exp_t;

  exp_t exp_q[$];

  always #5 clk = ~clk;

  display_scheduler #(.SCAN_DIV(SCAN_DIV)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_a     (req_a),
    .req_b     (req_b),
    .val_a     (val_a),
    .val_b     (val_b),
    .gnt_a     (gnt_a),
    .gnt_b     (gnt_b),
    .conv_in   (conv_in),
    .conv_decs (conv_decs),
    .conv_unis (conv_unis),
    .conv_dis1 (conv_dis1),
    .conv_dis2 (conv_dis2),
    .decs_q    (decs_q),
    .unis_q    (unis_q),
    .seg       (seg),
    .an        (an),
    .busy      (busy)
  );

  function automatic logic [0:6] seg7(input logic [3:0] d);
    case (d)
      4'd0: seg7 = 7'b0000001;
      4'd1: seg7 = 7'b1001111;
      4'd2: seg7 = 7'b0010010;
      4'd3: seg7 = 7'b0000110;
      4'd4: seg7 = 7'b1001100;
      4'd5: seg7 = 7'b0100100;
      4'd6: seg7 = 7'b0100000;
      4'd7: seg7 = 7'b0001111;
      4'd8: seg7 = 7'b0000000;
      4'd9: seg7 = 7'b0000100;
      default: seg7 = 7'b1111111;
    endcase
  endfunction

  function automatic logic [0:6] tens_seg(input logic [3:0] v);
`ifdef LEADING_ZERO_BLANK_EN
    tens_seg = (v / 10 == 0) ? 7'b1111111 : seg7(v / 10);
`else
    tens_seg = seg7(v / 10);
`endif
  endfunction

  // External converter model.
  always_comb begin
    conv_decs = conv_in / 4'd10;
    conv_unis = conv_in % 4'd10;
    conv_dis1 = seg7(conv_decs);
    conv_dis2 = seg7(conv_unis);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Grant/capture monitor: pops one expectation per grant pulse and checks
  // the capture two cycles later when busy drops.
  initial begin : monitor
    exp_t cur;
    logic pend;
    int   lat;
    pend = 1'b0;
    lat  = 0;
    cur  = '0;
    forever begin
      @(negedge clk);
      if (gnt_a || gnt_b) begin
        check_eq("gnt_onehot", gnt_a & gnt_b, 0);
        if (exp_q.size() == 0) begin
          check_eq("unexpected_gnt", {gnt_a, gnt_b}, 0);
        end else begin
          cur = exp_q.pop_front();
          check_eq("gnt_b", gnt_b, cur.is_b);
          check_eq("gnt_a", gnt_a, !cur.is_b);
          check_eq("conv_in", conv_in, cur.val);
          pend = 1'b1;
          lat  = 0;
        end
      end else if (pend) begin
        if (!rst_n) begin
          pend = 1'b0;
        end else begin
          lat++;
          if (!busy) begin
            check_eq("done_latency", lat, 2);
            check_eq("decs_q", decs_q, cur.val / 10);
            check_eq("unis_q", unis_q, cur.val % 10);
            pend = 1'b0;
          end
        end
      end
    end
  end

  task automatic wait_idle();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!busy) break;
    end
    check_eq("idle_timeout", busy, 0);
  endtask

  task automatic single(input logic is_b, input logic [3:0] v);
    exp_t e;
    e.is_b = is_b;
    e.val  = v;
    exp_q.push_back(e);
    if (is_b) begin req_b = 1'b1; val_b = v; end
    else      begin req_a = 1'b1; val_a = v; end
    @(negedge clk);
    req_a = 1'b0;
    req_b = 1'b0;
    wait_idle();
  endtask

  // Watches the scan for n cycles: seg must match the selected digit and
  // the anodes must toggle every SCAN_DIV cycles.
  task automatic observe(input int n, input logic [0:6] exp_t_seg, input logic [0:6] exp_u_seg);
    logic [1:0] prev_an;
    int         last_tog;
    prev_an  = an;
    last_tog = -1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (an == 2'b10) begin
        check_eq("seg_tens", seg, exp_t_seg);
      end else begin
        check_eq("an_code", an, 2'b01);
        check_eq("seg_units", seg, exp_u_seg);
      end
      if (an != prev_an) begin
        if (last_tog >= 0) check_eq("an_period", i - last_tog, SCAN_DIV);
        last_tog = i;
        prev_an  = an;
      end
    end
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stim
    exp_t e;
    rst_n = 1'b0;
    req_a = 1'b0;
    req_b = 1'b0;
    val_a = 4'd0;
    val_b = 4'd0;
    repeat (3) @(negedge clk);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_gnt", {gnt_a, gnt_b}, 0);
    check_eq("rst_conv_in", conv_in, 0);
    check_eq("rst_decs", decs_q, 0);
    check_eq("rst_unis", unis_q, 0);
    check_eq("rst_an", an, 2'b10);
    check_eq("rst_seg", seg, 7'b0000001);
    rst_n = 1'b1;
    @(negedge clk);

    // Lone requests, including B twice in a row.
    single(1'b0, 4'd13);
    single(1'b1, 4'd0);
    single(1'b1, 4'd9);
    single(1'b0, 4'd10);

    // Both held from reset: strict alternation starting with A.
    rst_n = 1'b0;
    req_a = 1'b1;
    req_b = 1'b1;
    val_a = 4'd4;
    val_b = 4'd11;
    for (int i = 0; i < 4; i++) begin
      e.is_b = i[0];
      e.val  = i[0] ? 4'd11 : 4'd4;
      exp_q.push_back(e);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0) break;
    end
    req_a = 1'b0;
    req_b = 1'b0;
    check_eq("rr_drain", exp_q.size(), 0);
    wait_idle();

    // Scan with value 15.
    single(1'b1, 4'd15);
    observe(20, tens_seg(4'd15), seg7(4'd5));

    // Single-digit value: tens slot depends on leading-zero blanking.
    single(1'b0, 4'd7);
    observe(12, tens_seg(4'd7), seg7(4'd7));

    // Reset during GRANT aborts the operation.
    e.is_b = 1'b0;
    e.val  = 4'd5;
    exp_q.push_back(e);
    req_a = 1'b1;
    val_a = 4'd5;
    @(negedge clk);
    req_a = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    check_eq("abort_gnt", {gnt_a, gnt_b}, 0);
    check_eq("abort_decs", decs_q, 0);
    check_eq("abort_unis", unis_q, 0);
    check_eq("abort_an", an, 2'b10);
    check_eq("abort_seg", seg, 7'b0000001);
    check_eq("abort_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check_eq("abort_no_capture", unis_q, 0);
    check_eq("queue_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
